fifo_wr_arbiter: RTL

//  Shares the single write port of the async FIFO among NREQ requesters in the wclk domain.

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = arbitrating, GRANT = owner may write)
//   STAT_W      : width of each per-requester beat counter (optional statistics)
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans last+1 .. last+NREQ (mod NREQ) and returns the first asserted request.
// Ports:
//   req   in  NREQ  request vector
//   last  in  IW    index that won most recently (lowest priority this round)
//   idx   out IW    selected index (0 when nothing is requested)
//   found out 1     at least one request is asserted
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            found
);
  always_comb begin
    logic [IW-1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single write port of an async FIFO among NREQ write-domain clients.
// Round-robin arbitration with bursts bounded to BURST beats, throttled by wfull.
// Every grant costs one IDLE arbitration cycle before its first beat.
// Ports:
//   wclk, wrst_n        write clock, async active-low reset
//   req_valid/req_data  per-requester word offers (lane i at [i*DSIZE +: DSIZE])
//   req_ready           one-hot acceptance strobe toward the owner
//   wfull               FIFO full flag (wclk domain)
//   winc/wdata          FIFO write enable and data
//   wgnt_id, busy       current owner index, grant active
//   xfer_cnt            per-requester saturating beat counters
//                       (present only when WR_ARB_STATS_EN is defined)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(BURST) + 1
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [IW-1:0]           wgnt_id,
  output logic                    busy
`ifdef WR_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]  xfer_cnt
`endif
);

  arb_state_t    state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] rr_last, rr_last_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          xfer;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .last  (rr_last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_last  <= IW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_last  <= rr_last_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_last_nx  = rr_last;
    beat_cnt_nx = beat_cnt;
    req_ready   = '0;
    xfer        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nx    = pick_idx;
          beat_cnt_nx = '0;
          state_nx    = GRANT;
        end
      end
      GRANT: begin
        // ready follows wfull only; the owner's valid decides whether a beat moves
        req_ready = (NREQ'(1) << owner) & {NREQ{!wfull}};
        xfer      = req_valid[owner] & !wfull;
        if (!req_valid[owner]) begin
          rr_last_nx = owner;
          state_nx   = IDLE;
        end else if (xfer) begin
          if (beat_cnt == CW'(BURST - 1)) begin
            rr_last_nx = owner;
            state_nx   = IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign winc    = xfer;
  assign wdata   = req_data[owner*DSIZE +: DSIZE];
  assign wgnt_id = owner;
  assign busy    = (state == GRANT);

`ifdef WR_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
        cnt <= '0;
      end else if (xfer && owner == IW'(i) && cnt != {STAT_W{1'b1}}) begin
        cnt <= cnt + STAT_W'(1);
      end
    end
    assign xfer_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
